// File: rtl/hms_time_counter_if.sv
// Control inputs and BCD time/status outputs of the hours:minutes:seconds counter.
// The master side drives tick/run/set pulses; the slave side is the counter.
interface hms_time_counter_if;
  logic       tick_in;
  logic       run;
  logic       inc_min;
  logic       inc_hr;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic [3:0] hr_ones;
  logic [1:0] hr_tens;
  logic       sec_led;
  logic       day_wrap;

  modport master (
    output tick_in, run, inc_min, inc_hr,
    input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, sec_led, day_wrap
  );

  modport slave (
    input  tick_in, run, inc_min, inc_hr,
    output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, sec_led, day_wrap
  );
endinterface

// File: rtl/hms_time_counter.sv
// 24-hour BCD clock advanced by rising edges of a same-domain slow tick, with
// run/stop control and minute/hour set pulses. All outputs come straight from flops.
module hms_time_counter #(
  parameter int unsigned EDGES_PER_SEC = 1
) (
  input  logic               sys_clk,
  input  logic               reset,
  hms_time_counter_if.slave  bus
);

  localparam logic [7:0] PRESC_MAX = 8'(EDGES_PER_SEC - 1);

  // Time is held as packed BCD: {tens, ones}, so 59 reads as 7'h59 and 23 as 6'h23.
  logic [6:0] sec_q, sec_d;
  logic [6:0] min_q, min_d;
  logic [5:0] hr_q,  hr_d;
  logic [7:0] presc_q, presc_d;
  logic       tick_q;
  logic       led_q, led_d;
  logic       dw_q, dw_d;
  logic       edge_w;

  function automatic logic [6:0] inc60(input logic [6:0] x);
    if (x[3:0] == 4'd9)
      inc60 = (x[6:4] == 3'd5) ? 7'h00 : {x[6:4] + 3'd1, 4'd0};
    else
      inc60 = {x[6:4], x[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] inc24(input logic [5:0] x);
    if (x == 6'h23)
      inc24 = 6'h00;
    else if (x[3:0] == 4'd9)
      inc24 = {x[5:4] + 2'd1, 4'd0};
    else
      inc24 = {x[5:4], x[3:0] + 4'd1};
  endfunction

  assign edge_w = bus.tick_in & ~tick_q;

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    presc_d = presc_q;
    led_d   = led_q;
    dw_d    = 1'b0;
    // Set pulses win over a coincident edge; that edge is simply dropped.
    if (bus.inc_min || bus.inc_hr) begin
      if (bus.inc_min) begin
        min_d   = inc60(min_q);
        sec_d   = 7'h00;
        presc_d = 8'd0;
      end
      if (bus.inc_hr) hr_d = inc24(hr_q);
    end else if (edge_w && bus.run) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = 8'd0;
        led_d   = ~led_q;
        sec_d   = inc60(sec_q);
        if (sec_q == 7'h59) begin
          min_d = inc60(min_q);
          if (min_q == 7'h59) begin
            hr_d = inc24(hr_q);
            dw_d = (hr_q == 6'h23);
          end
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      // tick_q starts high so a tick already high out of reset is not an edge.
      tick_q  <= 1'b1;
      sec_q   <= 7'h00;
      min_q   <= 7'h00;
      hr_q    <= 6'h00;
      presc_q <= 8'd0;
      led_q   <= 1'b0;
      dw_q    <= 1'b0;
    end else begin
      tick_q  <= bus.tick_in;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      presc_q <= presc_d;
      led_q   <= led_d;
      dw_q    <= dw_d;
    end
  end

  assign bus.sec_ones = sec_q[3:0];
  assign bus.sec_tens = sec_q[6:4];
  assign bus.min_ones = min_q[3:0];
  assign bus.min_tens = min_q[6:4];
  assign bus.hr_ones  = hr_q[3:0];
  assign bus.hr_tens  = hr_q[5:4];
  assign bus.sec_led  = led_q;
  assign bus.day_wrap = dw_q;

endmodule

// File: doc/hms_time_counter.md
# hms_time_counter

Downstream consumer of the slow clock produced by the LED clock divider. It edge-detects that slow clock in the `sys_clk` domain and advances a 24-hour BCD hours:minutes:seconds count. It also provides run/stop control and minute/hour set pulses. Outputs drive the board's display/LED logic directly.

## Interface
- `EDGES_PER_SEC`, default 1: rising edges of `tick_in` per one-second advance; legal range 1..255.
- `sys_clk` input 1: system clock; single clock domain, all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `tick_in` input 1: divider output (a level clock registered in the `sys_clk` domain); only rising edges are used.
- `run` input 1: level; 1 = count, 0 = hold time.
- `inc_min` input 1: single-cycle pulse; advance minutes by one.
- `inc_hr` input 1: single-cycle pulse; advance hours by one.
- `sec_ones` output 4: BCD 0..9.
- `sec_tens` output 3: BCD 0..5.
- `min_ones` output 4: BCD 0..9.
- `min_tens` output 3: BCD 0..5.
- `hr_ones` output 4: BCD 0..9; 0..3 when `hr_tens`=2.
- `hr_tens` output 2: BCD 0..2.
- `sec_led` output 1: toggles on every seconds advance.
- `day_wrap` output 1: one-cycle pulse on the 23:59:59→00:00:00 advance.

## Operation
- **Reset values:**
  - All digits 0.
  - `sec_led`=0, `day_wrap`=0.
  - Prescaler=0.
  - `tick_q`=1, so a `tick_in` that is already high out of reset is not an edge.
- **Edge detect:** `tick_q` registers `tick_in` every cycle. `edge = tick_in & ~tick_q`. No synchronizer is used, because the input is same-domain.
- **Prescaler:** 8-bit.
  - On `edge` with `run`=1: if prescaler = EDGES_PER_SEC-1, clear it and issue a one-second advance; otherwise increment it.
  - On `edge` with `run`=0: the edge is discarded and the prescaler holds.
  - `run` falling does not clear the prescaler.
- **Seconds advance:** ripple carry sec_ones → sec_tens → min_ones → min_tens → hr_ones → hr_tens.
  - Each digit wraps at its limit (9, 5, 9, 5) and carries into the next digit.
  - Hours wrap 23→00.
  - `sec_led` toggles on every advance.
  - `day_wrap`=1 for exactly the cycle after the 23:59:59 advance, else 0.
- **inc_min:**
  - Minutes +1, wrapping 59→00 with no carry into hours.
  - Seconds cleared to 00; prescaler cleared.
  - Works regardless of `run`.
- **inc_hr:** hours +1, wrapping 23→00. Minutes, seconds and prescaler are untouched. Works regardless of `run`.
- **Priority:**
  - If `inc_min` or `inc_hr` is high in the same cycle as a qualifying edge, the set operation(s) apply and the edge is dropped: no advance, prescaler unchanged unless cleared by `inc_min`, no `sec_led` toggle, no `day_wrap`.
  - `inc_min` and `inc_hr` together apply both, each without carry.
- **Reset** overrides everything in any cycle, including mid-carry and mid-set.
- Digit registers never hold non-BCD or out-of-range values.

## Timing
- Latency: a `tick_in` rising in cycle n is seen as an edge in cycle n. The count is updated at the clock ending cycle n and is visible in cycle n+1.
- The set pulses have the same 1-cycle latency.
- `day_wrap` is asserted in cycle n+1 only.
- A held-high `tick_in` produces one edge. The minimum edge spacing supported is 2 cycles (high one cycle, low one cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset with `tick_in` held high:**
  - Stimulus: assert `reset` for 2 cycles, release, keep `tick_in`=1 for 10 cycles.
  - Required: time stays 00:00:00, `sec_led`=0, `day_wrap` never asserts.
- **Carry chain:**
  - Stimulus: from 00:00:58, run=1, EDGES_PER_SEC=1, apply 2 edges.
  - Required: 00:00:59, then 00:01:00; `sec_led` toggles twice.
  - Stimulus: from 09:59:59, apply 1 edge.
  - Required: 10:00:00.
- **Day wrap:**
  - Stimulus: from 23:59:59, apply 1 edge.
  - Required: 00:00:00 and `day_wrap` high for exactly 1 cycle.
  - Stimulus: `inc_hr` at 23:10:05.
  - Required: 00:10:05 with no `day_wrap`.
- **Run/prescale:**
  - Stimulus: EDGES_PER_SEC=3, run=1, apply 2 edges, drop run, apply 5 edges, raise run, apply 1 edge.
  - Required: time advances exactly 00:00:00→00:00:01 on that final edge.
- **Set pulses:**
  - Stimulus: `inc_min` at 12:59:37.
  - Required: 12:00:00.
  - Stimulus: `inc_min` and `inc_hr` together at 05:20:10.
  - Required: 06:21:00.
- **Collision:**
  - Stimulus: `inc_hr` in the same cycle as an edge at 03:04:05.
  - Required: 04:04:05; no seconds advance, no `sec_led` toggle.
  - Stimulus: `reset` asserted in the same cycle as an edge at 23:59:59.
  - Required: 00:00:00 with `day_wrap`=0.
